axi4_slave_wr_mux: RTL and testbench
====================================

Name: axi4_slave_wr_mux

Overview:
- Write-path multiplexer that sits directly downstream of the per-slave arbiter.
- Drives the arbiter's per-master request inputs, consumes its registered one-hot grant, and locks onto the granted master for one complete write transaction: one AW handshake, then awlen+1 W beats.
- Routes that master's AW and W channels to a single slave port and returns ready only to it.
- The lock holds through the burst, so a grant change mid-burst never reorders or interleaves write data.

Parameters:
- NUM_MASTERS, 4, number of master ports (1..4, matches the arbiter).
- ID_WIDTH, 4, AWID width.
- ADDR_WIDTH, 32, AWADDR width.
- DATA_WIDTH, 32, WDATA width; WSTRB width is DATA_WIDTH/8.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous active-high reset.
- m_awvalid  in  NUM_MASTERS  per-master AWVALID.
- m_awid  in  NUM_MASTERS*ID_WIDTH  packed AWID; master i at slice i.
- m_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed AWADDR.
- m_awlen  in  NUM_MASTERS*8  packed AWLEN.
- m_awready  out  NUM_MASTERS  per-master AWREADY.
- m_wvalid  in  NUM_MASTERS  per-master WVALID.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed WDATA.
- m_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  packed WSTRB.
- m_wlast  in  NUM_MASTERS  per-master WLAST.
- m_wready  out  NUM_MASTERS  per-master WREADY.
- arb_request  out  NUM_MASTERS  request vector to the arbiter.
- arb_grant  in  NUM_MASTERS  registered one-hot grant from the arbiter.
- s_awvalid, s_awid, s_awaddr, s_awlen  out  1/ID_WIDTH/ADDR_WIDTH/8  slave AW channel.
- s_awready  in  1  slave AWREADY.
- s_wvalid, s_wdata, s_wstrb, s_wlast  out  1/DATA_WIDTH/DATA_WIDTH/8/1  slave W channel.
- s_wready  in  1  slave WREADY.
- busy  out  1  high whenever the state is not IDLE.
- sel  out  2  index of the locked master; valid while busy.
- wlast_err  out  1  one-cycle pulse on a WLAST mismatch.

Behaviour:
- Reset (areset high at a rising edge):
  - State goes to IDLE; sel=0, beat counter=0, latched awlen=0.
  - All outputs are 0 from the next cycle, including every ready, every valid, busy and wlast_err.
  - Reset mid-burst abandons the transaction; no further beats are forwarded.
- Three-state FSM: IDLE, ADDR, DATA.
- IDLE:
  - arb_request = m_awvalid; s_* valids = 0; all m_* readies = 0.
  - If arb_grant != 0, latch sel = index of the lowest set grant bit (a non-one-hot grant is tolerated this way) and go to ADDR.
  - If arb_grant == 0, remain in IDLE.
  - Grant-to-ADDR latency is 1 cycle.
- ADDR:
  - arb_request = 0.
  - s_awvalid/id/addr/len = master[sel] AW fields; m_awready[sel] = s_awready; other readies = 0.
  - On s_awvalid & s_awready: latch awlen, clear the beat counter, go to DATA.
  - If master[sel] drops awvalid (protocol violation), wait in ADDR; there is no timeout.
- DATA:
  - s_wvalid/wdata/wstrb = master[sel] W fields; m_wready[sel] = s_wready; other readies = 0.
  - s_wlast is generated internally as (beat counter == awlen); m_wlast is not forwarded.
  - On each s_wvalid & s_wready handshake the beat counter increments (8 bits, max 255).
  - On the handshake with counter == awlen, go to IDLE.
  - Back-to-back transactions from the same master are therefore separated by at least 1 IDLE cycle.
- wlast_err pulses for 1 cycle on any W handshake where m_wlast[sel] != s_wlast. The beat is still forwarded and the counter remains authoritative.
- awlen=0 yields one W beat with s_wlast=1 on the first beat.
- W beats presented by master[sel] before the AW handshake completes are held off: m_wready stays 0 until DATA.
- No combinational path exists from arb_grant to any s_* output (grant is sampled only in IDLE). Combinational ready pass-through from s_*ready to m_*ready is required.

Test Plan:
- Master 1 requests, awlen=3, slave always ready -> arb_request=4'b0010 in IDLE; s_awaddr = master 1 address one cycle after grant; exactly 4 W beats forwarded with s_wlast on beat 4; busy falls the cycle after the last beat.
- Masters 0 and 2 request simultaneously with grant 4'b0100 -> sel=2; master 0's m_awready and m_wready stay 0 throughout; after master 2's burst, master 0 is served once its grant arrives.
- awlen=0 with s_wready toggling 0,1 -> a single beat is forwarded; s_wlast=1; the FSM returns to IDLE after the accepted beat only.
- Master asserts m_wlast on beat 2 of an awlen=3 burst -> wlast_err pulses exactly once; 4 beats are still forwarded; s_wlast only on beat 4.
- areset asserted during beat 2 of an awlen=7 burst -> all valids and readies are 0 the next cycle, state is IDLE, and a new transaction after reset starts with beat counter 0.
- arb_grant=4'b0110 (illegal) -> sel=1 and only master 1 is routed.

Source files
------------

// File: rtl/axi4_slave_wr_mux.sv
// Write-path mux for one slave port: locks onto the arbiter-granted master for
// one AW handshake plus awlen+1 W beats, so write data is never interleaved.
//
// state | meaning
// IDLE  | forward AW requests to the arbiter, wait for a grant
// ADDR  | route master[sel] AW channel to the slave
// DATA  | route master[sel] W channel, count beats, generate WLAST
module axi4_slave_wr_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [NUM_MASTERS-1:0]               m_awvalid,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]      m_awid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_awaddr,
    input  logic [NUM_MASTERS*8-1:0]             m_awlen,
    output logic [NUM_MASTERS-1:0]               m_awready,
    input  logic [NUM_MASTERS-1:0]               m_wvalid,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_wstrb,
    input  logic [NUM_MASTERS-1:0]               m_wlast,
    output logic [NUM_MASTERS-1:0]               m_wready,
    output logic [NUM_MASTERS-1:0]               arb_request,
    input  logic [NUM_MASTERS-1:0]               arb_grant,
    output logic                                 s_awvalid,
    output logic [ID_WIDTH-1:0]                  s_awid,
    output logic [ADDR_WIDTH-1:0]                s_awaddr,
    output logic [7:0]                           s_awlen,
    input  logic                                 s_awready,
    output logic                                 s_wvalid,
    output logic [DATA_WIDTH-1:0]                s_wdata,
    output logic [DATA_WIDTH/8-1:0]              s_wstrb,
    output logic                                 s_wlast,
    input  logic                                 s_wready,
    output logic                                 busy,
    output logic [1:0]                           sel,
    output logic                                 wlast_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  grant_idx;

    // Lowest set grant bit wins, which also absorbs a non-one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (arb_grant[i]) grant_idx = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        beat_d      = beat_q;
        len_d       = len_q;
        arb_request = '0;
        m_awready   = '0;
        m_wready    = '0;
        s_awvalid   = 1'b0;
        s_awid      = '0;
        s_awaddr    = '0;
        s_awlen     = '0;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wlast     = 1'b0;
        wlast_err   = 1'b0;

        case (state_q)
            IDLE: begin
                arb_request = m_awvalid;
                if (|arb_grant) begin
                    sel_d   = grant_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_awvalid        = m_awvalid[sel_q];
                s_awid           = m_awid[int'(sel_q)*ID_WIDTH +: ID_WIDTH];
                s_awaddr         = m_awaddr[int'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH];
                s_awlen          = m_awlen[int'(sel_q)*8 +: 8];
                m_awready[sel_q] = s_awready;
                if (s_awvalid && s_awready) begin
                    len_d   = s_awlen;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                s_wvalid        = m_wvalid[sel_q];
                s_wdata         = m_wdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb         = m_wstrb[int'(sel_q)*STRB_WIDTH +: STRB_WIDTH];
                // The beat counter, not the master's WLAST, defines the burst end.
                s_wlast         = (beat_q == len_q);
                m_wready[sel_q] = s_wready;
                if (s_wvalid && s_wready) begin
                    beat_d    = beat_q + 8'd1;
                    wlast_err = (m_wlast[sel_q] != s_wlast);
                    if (s_wlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign sel  = sel_q;

endmodule

// File: tb/tb_axi4_slave_wr_mux.sv
// Randomized bench for axi4_slave_wr_mux: each scenario runs whole write
// transactions and compares the forwarded traffic against a per-burst model.
module tb_axi4_slave_wr_mux;

    localparam int NM = 4;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic aclk = 1'b0;
    logic areset;
    logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic [NM*IW-1:0] m_awid;
    logic [NM*AW-1:0] m_awaddr;
    logic [NM*8-1:0]  m_awlen;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*SW-1:0] m_wstrb;
    logic [NM-1:0]    arb_request, arb_grant;
    logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, busy, wlast_err;
    logic [IW-1:0] s_awid;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [1:0]    sel;

    always #5 aclk = ~aclk;

    axi4_slave_wr_mux #(.NUM_MASTERS(NM), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wready(m_wready), .arb_request(arb_request), .arb_grant(arb_grant),
        .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wready(s_wready), .busy(busy), .sel(sel), .wlast_err(wlast_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference burst: what the granted master offers and what must reach the slave.
    logic [DW-1:0] md [256];
    logic [SW-1:0] ms [256];
    logic [IW-1:0] exp_id;
    logic [AW-1:0] exp_addr;
    logic [NM-1:0] bystand;

    // Observations collected while a transaction runs.
    logic [DW-1:0] od [$];
    logic [SW-1:0] os [$];
    logic          ol [$];
    logic [NM-1:0] obs_req;
    logic [1:0]    obs_sel;
    logic [IW-1:0] obs_id;
    logic [AW-1:0] obs_addr;
    logic [7:0]    obs_len;
    logic [7:0]    obs_after_rst;
    int obs_lat, obs_leak, obs_early, obs_err, obs_refused, obs_tail;
    logic timeout, did_rst;

    task automatic do_txn(input int m, input logic [NM-1:0] g, input int len,
                          input int rmode, input int bad, input int rst_beat);
        int wi, last_cyc;
        logic aw_hs, seen_busy, done, tg;
        exp_id   = IW'($urandom);
        exp_addr = $urandom;
        for (int i = 0; i <= len; i++) begin
            md[i] = $urandom;
            ms[i] = SW'($urandom);
        end
        od.delete(); os.delete(); ol.delete();
        obs_lat = -1; obs_leak = 0; obs_early = 0; obs_err = 0; obs_refused = 0; obs_tail = -1;
        obs_sel = '0; obs_id = '0; obs_addr = '0; obs_len = '0; obs_after_rst = '1;
        timeout = 1'b0; did_rst = 1'b0;
        wi = 0; last_cyc = -1; aw_hs = 1'b0; seen_busy = 1'b0; done = 1'b0; tg = 1'b0;

        @(negedge aclk);
        m_awid[m*IW +: IW]   = exp_id;
        m_awaddr[m*AW +: AW] = exp_addr;
        m_awlen[m*8 +: 8]    = 8'(len);
        m_awvalid = bystand | NM'(1 << m);
        m_wvalid  = bystand | NM'(1 << m);
        m_wdata[m*DW +: DW] = md[0];
        m_wstrb[m*SW +: SW] = ms[0];
        m_wlast[m] = (len == 0) || (bad == 0);
        arb_grant = '0; s_awready = 1'b0; s_wready = 1'b0;
        #1 obs_req = arb_request;
        @(negedge aclk);
        arb_grant = g;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge aclk);
            arb_grant = '0;
            s_awready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : tg;
            m_awvalid[m] = !aw_hs;
            m_wvalid[m]  = (wi <= len);
            if (wi <= len) begin
                m_wdata[m*DW +: DW] = md[wi];
                m_wstrb[m*SW +: SW] = ms[wi];
                m_wlast[m] = (wi == len) || (wi == bad);
            end
            if (rst_beat >= 0 && wi == rst_beat) begin
                areset = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                m_awvalid = bystand;
                m_wvalid  = bystand;
                #1 obs_after_rst = {s_awvalid, s_wvalid, s_wlast, |m_awready, |m_wready,
                                    busy, wlast_err, |arb_request};
                did_rst = 1'b1;
                break;
            end
            #1;
            if (busy) seen_busy = 1'b1;
            if (s_awvalid && obs_lat < 0) begin
                obs_lat = cyc + 1; obs_sel = sel;
                obs_id = s_awid; obs_addr = s_awaddr; obs_len = s_awlen;
            end
            if (((m_awready | m_wready) & ~NM'(1 << m)) != '0) obs_leak++;
            if (m_wready[m] && !s_wvalid) obs_early++;
            if (s_wvalid && !s_wready) obs_refused++;
            if (s_wvalid && s_wready) begin
                od.push_back(s_wdata); os.push_back(s_wstrb); ol.push_back(s_wlast);
                last_cyc = cyc;
            end
            if (wlast_err) obs_err++;
            if (m_awvalid[m] && m_awready[m]) aw_hs = 1'b1;
            if (m_wvalid[m] && m_wready[m]) wi++;
            if (s_wvalid) tg = ~tg;
            if (seen_busy && !busy) begin
                obs_tail = cyc - last_cyc;
                done = 1'b1;
                break;
            end
        end
        timeout = !done && !did_rst;
        m_awvalid = bystand;
        m_wvalid  = bystand;
        m_wlast   = '0;
    endtask

    task automatic test_reset();
        areset = 1'b1; m_awvalid = '0; m_wvalid = '0; m_wlast = '0; arb_grant = '0;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_wdata = '0; m_wstrb = '0;
        s_awready = 1'b1; s_wready = 1'b1; bystand = '0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        #1;
        vectors++;
        if ({s_awvalid, s_wvalid, s_wlast, m_awready, m_wready, busy, wlast_err, sel, arb_request} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: got %0h, want 0",
                {s_awvalid, s_wvalid, s_wlast, m_awready, m_wready, busy, wlast_err, sel, arb_request}); end
    endtask

    task automatic test_basic();
        do_txn(1, 4'b0010, 3, 0, -1, -1);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %0b, want 0", timeout); end
        vectors++; if (obs_req !== 4'b0010) begin miscompares++; $display("FAIL basic_request: got %b, want 0010", obs_req); end
        vectors++; if (obs_lat !== 1) begin miscompares++; $display("FAIL basic_grant_latency: got %0d, want 1", obs_lat); end
        vectors++; if (obs_addr !== exp_addr || obs_id !== exp_id || obs_len !== 8'd3)
            begin miscompares++; $display("FAIL basic_aw: got %h/%h/%0d, want %h/%h/3", obs_addr, obs_id, obs_len, exp_addr, exp_id); end
        vectors++; if (obs_sel !== 2'd1) begin miscompares++; $display("FAIL basic_sel: got %0d, want 1", obs_sel); end
        vectors++; if (od.size() !== 4) begin miscompares++; $display("FAIL basic_beats: got %0d, want 4", od.size()); end
        for (int i = 0; i < od.size() && i < 4; i++) begin
            vectors++;
            if ({od[i], os[i], ol[i]} !== {md[i], ms[i], (i == 3)})
                begin miscompares++; $display("FAIL basic_beat%0d: got %h/%h/%b, want %h/%h/%b", i, od[i], os[i], ol[i], md[i], ms[i], (i == 3)); end
        end
        vectors++; if (obs_tail !== 1) begin miscompares++; $display("FAIL basic_busy_fall: got %0d, want 1", obs_tail); end
        vectors++; if (obs_leak !== 0 || obs_early !== 0 || obs_err !== 0)
            begin miscompares++; $display("FAIL basic_clean: got leak %0d early %0d err %0d, want 0", obs_leak, obs_early, obs_err); end
    endtask

    task automatic test_two_masters();
        int len;
        bystand = 4'b0001;
        len = $urandom_range(0, 7);
        do_txn(2, 4'b0100, len, 1, -1, -1);
        vectors++; if (obs_req !== 4'b0101) begin miscompares++; $display("FAIL two_request: got %b, want 0101", obs_req); end
        vectors++; if (obs_sel !== 2'd2 || timeout !== 1'b0) begin miscompares++; $display("FAIL two_sel2: got %0d to %b, want 2 to 0", obs_sel, timeout); end
        vectors++; if (obs_leak !== 0) begin miscompares++; $display("FAIL two_m0_ready: got %0d, want 0", obs_leak); end
        vectors++; if (od.size() !== len + 1) begin miscompares++; $display("FAIL two_beats2: got %0d, want %0d", od.size(), len + 1); end
        for (int i = 0; i < od.size() && i <= len; i++) begin
            vectors++;
            if ({od[i], ol[i]} !== {md[i], (i == len)})
                begin miscompares++; $display("FAIL two_beat%0d: got %h/%b, want %h/%b", i, od[i], ol[i], md[i], (i == len)); end
        end
        bystand = '0;
        len = $urandom_range(0, 7);
        do_txn(0, 4'b0001, len, 1, -1, -1);
        vectors++; if (obs_sel !== 2'd0 || timeout !== 1'b0) begin miscompares++; $display("FAIL two_sel0: got %0d to %b, want 0 to 0", obs_sel, timeout); end
        vectors++; if (obs_addr !== exp_addr) begin miscompares++; $display("FAIL two_addr0: got %h, want %h", obs_addr, exp_addr); end
        vectors++; if (od.size() !== len + 1) begin miscompares++; $display("FAIL two_beats0: got %0d, want %0d", od.size(), len + 1); end
    endtask

    task automatic test_len0();
        do_txn(3, 4'b1000, 0, 2, -1, -1);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL len0_timeout: got %0b, want 0", timeout); end
        vectors++; if (od.size() !== 1) begin miscompares++; $display("FAIL len0_beats: got %0d, want 1", od.size()); end
        vectors++; if (od.size() > 0 && {od[0], ol[0]} !== {md[0], 1'b1})
            begin miscompares++; $display("FAIL len0_last: got %h/%b, want %h/1", od[0], ol[0], md[0]); end
        vectors++; if (obs_refused < 1) begin miscompares++; $display("FAIL len0_refused: got %0d, want >=1", obs_refused); end
        vectors++; if (obs_tail !== 1) begin miscompares++; $display("FAIL len0_idle: got %0d, want 1", obs_tail); end
    endtask

    task automatic test_wlast_err();
        do_txn(0, 4'b0001, 3, 0, 1, -1);
        vectors++; if (obs_err !== 1) begin miscompares++; $display("FAIL werr_pulses: got %0d, want 1", obs_err); end
        vectors++; if (od.size() !== 4) begin miscompares++; $display("FAIL werr_beats: got %0d, want 4", od.size()); end
        for (int i = 0; i < od.size() && i < 4; i++) begin
            vectors++;
            if ({od[i], ol[i]} !== {md[i], (i == 3)})
                begin miscompares++; $display("FAIL werr_beat%0d: got %h/%b, want %h/%b", i, od[i], ol[i], md[i], (i == 3)); end
        end
    endtask

    task automatic test_reset_mid();
        do_txn(1, 4'b0010, 7, 0, -1, 1);
        vectors++; if (did_rst !== 1'b1) begin miscompares++; $display("FAIL rstmid_reached: got %0b, want 1", did_rst); end
        vectors++; if (obs_after_rst !== 8'h00) begin miscompares++; $display("FAIL rstmid_outputs: got %h, want 00", obs_after_rst); end
        vectors++; if (od.size() !== 1) begin miscompares++; $display("FAIL rstmid_beats: got %0d, want 1", od.size()); end
        do_txn(1, 4'b0010, 3, 0, -1, -1);
        vectors++; if (od.size() !== 4 || timeout !== 1'b0) begin miscompares++; $display("FAIL rstmid_next_beats: got %0d, want 4", od.size()); end
        for (int i = 0; i < od.size() && i < 4; i++) begin
            vectors++;
            if (ol[i] !== (i == 3)) begin miscompares++; $display("FAIL rstmid_next_last%0d: got %b, want %b", i, ol[i], (i == 3)); end
        end
        vectors++; if (obs_err !== 0) begin miscompares++; $display("FAIL rstmid_next_err: got %0d, want 0", obs_err); end
    endtask

    task automatic test_illegal_grant();
        bystand = 4'b0100;
        do_txn(1, 4'b0110, 2, 1, -1, -1);
        bystand = '0;
        m_awvalid = '0; m_wvalid = '0;
        vectors++; if (obs_sel !== 2'd1) begin miscompares++; $display("FAIL illegal_sel: got %0d, want 1", obs_sel); end
        vectors++; if (obs_id !== exp_id || obs_leak !== 0)
            begin miscompares++; $display("FAIL illegal_route: got id %h leak %0d, want id %h leak 0", obs_id, obs_leak, exp_id); end
        vectors++; if (od.size() !== 3 || timeout !== 1'b0) begin miscompares++; $display("FAIL illegal_beats: got %0d, want 3", od.size()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            int m, len;
            logic [NM-1:0] g, hi;
            m   = $urandom_range(0, NM - 1);
            len = $urandom_range(0, 15);
            hi  = NM'($urandom) & ~NM'((1 << (m + 1)) - 1);
            g   = hi | NM'(1 << m);
            bystand = NM'($urandom) & ~NM'(1 << m);
            do_txn(m, g, len, 1, -1, -1);
            vectors++; if (timeout !== 1'b0 || obs_sel !== 2'(m))
                begin miscompares++; $display("FAIL rand%0d_sel: got %0d to %b, want %0d to 0", k, obs_sel, timeout, m); end
            vectors++; if (obs_req !== (bystand | NM'(1 << m)))
                begin miscompares++; $display("FAIL rand%0d_req: got %b, want %b", k, obs_req, bystand | NM'(1 << m)); end
            vectors++; if (obs_addr !== exp_addr || obs_len !== 8'(len))
                begin miscompares++; $display("FAIL rand%0d_aw: got %h/%0d, want %h/%0d", k, obs_addr, obs_len, exp_addr, len); end
            vectors++; if (obs_leak !== 0 || obs_early !== 0 || obs_err !== 0)
                begin miscompares++; $display("FAIL rand%0d_clean: got %0d/%0d/%0d, want 0/0/0", k, obs_leak, obs_early, obs_err); end
            vectors++; if (od.size() !== len + 1) begin miscompares++; $display("FAIL rand%0d_beats: got %0d, want %0d", k, od.size(), len + 1); end
            for (int i = 0; i < od.size() && i <= len; i++) begin
                vectors++;
                if ({od[i], os[i], ol[i]} !== {md[i], ms[i], (i == len)})
                    begin miscompares++; $display("FAIL rand%0d_beat%0d: got %h/%h/%b, want %h/%h/%b", k, i, od[i], os[i], ol[i], md[i], ms[i], (i == len)); end
            end
        end
        bystand = '0;
        m_awvalid = '0; m_wvalid = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_masters();
        test_len0();
        test_wlast_err();
        test_reset_mid();
        test_illegal_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
